// File: rtl/procyon_cdb_arbiter.sv
// Purpose: per-FU result FIFOs feeding OPTN_CDB_DEPTH CDB lanes through a round-robin grant.
// Latency: 2 cycles minimum from i_fu_valid to o_cdb_en (FIFO write edge, then grant/output edge).
// Backpressure: o_fu_full is registered from the FIFO count; a same-cycle pop frees space one cycle later.
module procyon_cdb_arbiter #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_CDB_DEPTH     = 2,
  parameter int OPTN_FU_COUNT      = 4,
  parameter int OPTN_FU_FIFO_DEPTH = 2,
  parameter int FU_IDX_WIDTH       = (OPTN_FU_COUNT == 1) ? 1 : $clog2(OPTN_FU_COUNT)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic                          i_fu_valid [0:OPTN_FU_COUNT-1],
  input  logic [OPTN_DATA_WIDTH-1:0]    i_fu_data  [0:OPTN_FU_COUNT-1],
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_fu_tag   [0:OPTN_FU_COUNT-1],
  output logic                          o_fu_full  [0:OPTN_FU_COUNT-1],
  output logic                          o_cdb_en   [0:OPTN_CDB_DEPTH-1],
  output logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data [0:OPTN_CDB_DEPTH-1],
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag  [0:OPTN_CDB_DEPTH-1]
);

  localparam int PTR_W  = $clog2(OPTN_FU_FIFO_DEPTH);
  localparam int CNT_W  = $clog2(OPTN_FU_FIFO_DEPTH + 1);
  localparam int ENT_W  = OPTN_ROB_IDX_WIDTH + OPTN_DATA_WIDTH;
  localparam int SCAN_W = FU_IDX_WIDTH + 1;

  // FIFO storage and bookkeeping, one FIFO per functional unit
  logic [ENT_W-1:0]        r_mem   [0:OPTN_FU_COUNT-1][0:OPTN_FU_FIFO_DEPTH-1];
  logic [PTR_W-1:0]        r_rptr  [0:OPTN_FU_COUNT-1];
  logic [PTR_W-1:0]        r_wptr  [0:OPTN_FU_COUNT-1];
  logic [CNT_W-1:0]        r_count [0:OPTN_FU_COUNT-1];
  logic [OPTN_FU_COUNT-1:0] r_full;
  logic [FU_IDX_WIDTH-1:0] r_rr_ptr;

  logic [OPTN_FU_COUNT-1:0] w_push;
  logic [OPTN_FU_COUNT-1:0] w_pop;
  logic [OPTN_FU_COUNT-1:0] w_nonempty;
  logic [ENT_W-1:0]         w_head      [0:OPTN_FU_COUNT-1];
  logic [CNT_W-1:0]         w_count_nxt [0:OPTN_FU_COUNT-1];

  logic                    w_grant_vld [0:OPTN_CDB_DEPTH-1];
  logic [FU_IDX_WIDTH-1:0] w_grant_idx [0:OPTN_CDB_DEPTH-1];
  logic [FU_IDX_WIDTH-1:0] w_rr_nxt;
  logic                    w_any_grant;

  // Registered CDB lanes; payload is intentionally left unreset
  logic                    r_cdb_en  [0:OPTN_CDB_DEPTH-1];
  logic [ENT_W-1:0]        r_cdb_ent [0:OPTN_CDB_DEPTH-1];

  // Per-FU head, occupancy and accepted writes (writes are dropped in reset, flush or when full)
  always_comb begin
    for (int i = 0; i < OPTN_FU_COUNT; i++) begin
      w_nonempty[i] = (r_count[i] != '0);
      w_head[i]     = r_mem[i][r_rptr[i]];
      w_push[i]     = i_fu_valid[i] & ~r_full[i] & ~i_flush & n_rst;
    end
  end

  // Round-robin scan from r_rr_ptr: the n-th non-empty FIFO in scan order goes to lane n
  always_comb begin : arb
    logic [OPTN_FU_COUNT-1:0] taken;
    logic [SCAN_W-1:0]        scan;
    taken       = '0;
    scan        = '0;
    w_rr_nxt    = r_rr_ptr;
    w_any_grant = 1'b0;
    for (int k = 0; k < OPTN_CDB_DEPTH; k++) begin
      w_grant_vld[k] = 1'b0;
      w_grant_idx[k] = '0;
      for (int j = 0; j < OPTN_FU_COUNT; j++) begin
        scan = {1'b0, r_rr_ptr} + SCAN_W'(j);
        if (scan >= SCAN_W'(OPTN_FU_COUNT)) begin
          scan = scan - SCAN_W'(OPTN_FU_COUNT);
        end
        if (!w_grant_vld[k] && w_nonempty[scan[FU_IDX_WIDTH-1:0]] &&
            !taken[scan[FU_IDX_WIDTH-1:0]]) begin
          w_grant_vld[k] = 1'b1;
          w_grant_idx[k] = scan[FU_IDX_WIDTH-1:0];
        end
      end
      if (w_grant_vld[k]) begin
        taken[w_grant_idx[k]] = 1'b1;
        w_any_grant           = 1'b1;
        // Later lanes always land further along the scan, so the last grant sets the next start
        w_rr_nxt = (w_grant_idx[k] == FU_IDX_WIDTH'(OPTN_FU_COUNT - 1)) ?
                   '0 : w_grant_idx[k] + FU_IDX_WIDTH'(1);
      end
    end
    w_pop = taken;
  end

  // Next occupancy: simultaneous push and pop leaves the count unchanged
  always_comb begin
    for (int i = 0; i < OPTN_FU_COUNT; i++) begin
      w_count_nxt[i] = r_count[i];
      if (w_push[i] && !w_pop[i]) begin
        w_count_nxt[i] = r_count[i] + CNT_W'(1);
      end else if (!w_push[i] && w_pop[i]) begin
        w_count_nxt[i] = r_count[i] - CNT_W'(1);
      end
    end
  end

  // FIFO pointers, counts, full flags and round-robin pointer; reset and flush both empty everything
  always_ff @(posedge clk) begin
    if (!n_rst || i_flush) begin
      r_rr_ptr <= '0;
      r_full   <= '0;
      for (int i = 0; i < OPTN_FU_COUNT; i++) begin
        r_rptr[i]  <= '0;
        r_wptr[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      if (w_any_grant) begin
        r_rr_ptr <= w_rr_nxt;
      end
      for (int i = 0; i < OPTN_FU_COUNT; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        end
        r_count[i] <= w_count_nxt[i];
        r_full[i]  <= (w_count_nxt[i] == CNT_W'(OPTN_FU_FIFO_DEPTH));
      end
    end
  end

  // FIFO data write; no bypass, so a new entry is only visible at the head after this edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < OPTN_FU_COUNT; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= {i_fu_tag[i], i_fu_data[i]};
      end
    end
  end

  // CDB output register: enable is suppressed by reset or flush, payload follows the granted head
  always_ff @(posedge clk) begin
    for (int k = 0; k < OPTN_CDB_DEPTH; k++) begin
      r_cdb_ent[k] <= w_head[w_grant_idx[k]];
      if (!n_rst) begin
        r_cdb_en[k] <= 1'b0;
      end else begin
        r_cdb_en[k] <= w_grant_vld[k] & ~i_flush;
      end
    end
  end

  // Drive ports from the registered state
  always_comb begin
    for (int i = 0; i < OPTN_FU_COUNT; i++) begin
      o_fu_full[i] = r_full[i];
    end
    for (int k = 0; k < OPTN_CDB_DEPTH; k++) begin
      o_cdb_en[k]   = r_cdb_en[k];
      o_cdb_tag[k]  = r_cdb_ent[k][ENT_W-1:OPTN_DATA_WIDTH];
      o_cdb_data[k] = r_cdb_ent[k][OPTN_DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_procyon_cdb_arbiter.sv
// Bench for procyon_cdb_arbiter: directed scenarios plus random traffic against a queue-style model.
// Each cycle inputs change at the falling edge and outputs are compared at the next falling edge.
// Stimulus never presents a result to an FU whose FIFO the model says is full.
module tb_procyon_cdb_arbiter;
  localparam int DW  = 32;
  localparam int TW  = 5;
  localparam int CDB = 2;
  localparam int FU  = 4;
  localparam int FD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst;
  logic          i_flush;
  logic          i_fu_valid [0:FU-1];
  logic [DW-1:0] i_fu_data  [0:FU-1];
  logic [TW-1:0] i_fu_tag   [0:FU-1];
  logic          o_fu_full  [0:FU-1];
  logic          o_cdb_en   [0:CDB-1];
  logic [DW-1:0] o_cdb_data [0:CDB-1];
  logic [TW-1:0] o_cdb_tag  [0:CDB-1];

  procyon_cdb_arbiter #(
    .OPTN_DATA_WIDTH   (DW),
    .OPTN_ROB_IDX_WIDTH(TW),
    .OPTN_CDB_DEPTH    (CDB),
    .OPTN_FU_COUNT     (FU),
    .OPTN_FU_FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_flush   (i_flush),
    .i_fu_valid(i_fu_valid),
    .i_fu_data (i_fu_data),
    .i_fu_tag  (i_fu_tag),
    .o_fu_full (o_fu_full),
    .o_cdb_en  (o_cdb_en),
    .o_cdb_data(o_cdb_data),
    .o_cdb_tag (o_cdb_tag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Stimulus for the next edge
  logic          stim_rst;
  logic          stim_flush;
  logic          stim_vld [0:FU-1];
  logic [TW-1:0] stim_tag [0:FU-1];
  logic [DW-1:0] stim_dat [0:FU-1];

  // Reference model: each FIFO is an ordered list, entry 0 is the oldest
  logic [TW+DW-1:0] m_buf [0:FU-1][0:FD-1];
  int               m_cnt [0:FU-1];
  logic             m_full[0:FU-1];
  int               m_rr;
  logic             m_en  [0:CDB-1];
  logic [TW-1:0]    m_tag [0:CDB-1];
  logic [DW-1:0]    m_dat [0:CDB-1];

  task automatic model_step();
    int g[$];
    if (!stim_rst || stim_flush) begin
      for (int f = 0; f < FU; f++) begin
        m_cnt[f]  = 0;
        m_full[f] = 1'b0;
      end
      for (int k = 0; k < CDB; k++) m_en[k] = 1'b0;
      m_rr = 0;
      return;
    end
    // Grants: non-empty FUs in order starting at m_rr, at most CDB of them
    for (int j = 0; j < FU; j++) begin
      int f;
      f = (m_rr + j) % FU;
      if (m_cnt[f] > 0 && g.size() < CDB) g.push_back(f);
    end
    for (int k = 0; k < CDB; k++) begin
      m_en[k] = (k < g.size());
      if (k < g.size()) begin
        int f;
        f = g[k];
        {m_tag[k], m_dat[k]} = m_buf[f][0];
        for (int s = 0; s < FD - 1; s++) m_buf[f][s] = m_buf[f][s+1];
        m_cnt[f]--;
      end
    end
    if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % FU;
    // Writes accepted only if the FU was not full before this edge
    for (int f = 0; f < FU; f++) begin
      if (stim_vld[f] && !m_full[f]) begin
        m_buf[f][m_cnt[f]] = {stim_tag[f], stim_dat[f]};
        m_cnt[f]++;
      end
    end
    for (int f = 0; f < FU; f++) m_full[f] = (m_cnt[f] == FD);
  endtask

  task automatic compare_all();
    for (int k = 0; k < CDB; k++) begin
      check_eq($sformatf("cdb_en%0d", k), 64'(o_cdb_en[k]), 64'(m_en[k]));
      if (m_en[k]) begin
        check_eq($sformatf("cdb_tag%0d", k), 64'(o_cdb_tag[k]), 64'(m_tag[k]));
        check_eq($sformatf("cdb_data%0d", k), 64'(o_cdb_data[k]), 64'(m_dat[k]));
      end
    end
    for (int f = 0; f < FU; f++) begin
      check_eq($sformatf("fu_full%0d", f), 64'(o_fu_full[f]), 64'(m_full[f]));
    end
  endtask

  task automatic step();
    n_rst   = stim_rst;
    i_flush = stim_flush;
    for (int f = 0; f < FU; f++) begin
      i_fu_valid[f] = stim_vld[f];
      i_fu_tag[f]   = stim_tag[f];
      i_fu_data[f]  = stim_dat[f];
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_idle();
    stim_rst   = 1'b1;
    stim_flush = 1'b0;
    for (int f = 0; f < FU; f++) begin
      stim_vld[f] = 1'b0;
      stim_tag[f] = '0;
      stim_dat[f] = '0;
    end
  endtask

  task automatic set_fu(input int f, input logic [TW-1:0] t, input logic [DW-1:0] d);
    stim_vld[f] = 1'b1;
    stim_tag[f] = t;
    stim_dat[f] = d;
  endtask

  // Random result on FU f with low tags (0..15), only when the FIFO has room
  task automatic set_rand(input int f, input int pct);
    if (!m_full[f] && $urandom_range(0, 99) < 32'(pct))
      set_fu(f, TW'($urandom_range(0, 15)), $urandom);
  endtask

  logic saw_full1;
  logic fu3_seen;

  initial begin
    set_idle();

    // Reset held two cycles with every FU presenting a result
    stim_rst = 1'b0;
    for (int f = 0; f < FU; f++) set_fu(f, TW'(f), 32'h1111_0000 + 32'(f));
    step();
    step();
    set_idle();
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("reset_no_bcast", 64'(o_cdb_en[0] | o_cdb_en[1]), 64'd0);
    end

    // Single result on FU2: visible exactly one cycle, two cycles after valid
    set_fu(2, 5'h07, 32'hDEADBEEF);
    step();
    check_eq("single_lat1", 64'(o_cdb_en[0]), 64'd0);
    set_idle();
    step();
    check_eq("single_en0", 64'(o_cdb_en[0]), 64'd1);
    check_eq("single_tag", 64'(o_cdb_tag[0]), 64'h07);
    check_eq("single_data", 64'(o_cdb_data[0]), 64'hDEADBEEF);
    check_eq("single_en1", 64'(o_cdb_en[1]), 64'd0);
    step();
    check_eq("single_once", 64'(o_cdb_en[0]), 64'd0);

    // Round robin from pointer 0 (flush first to return the pointer to 0)
    stim_flush = 1'b1;
    step();
    set_idle();
    for (int f = 0; f < FU; f++) set_fu(f, TW'(5'h10 + f), 32'hA000_0000 + 32'(f));
    step();
    set_idle();
    step();
    check_eq("rr_c1_l0", 64'(o_cdb_tag[0]), 64'h10);
    check_eq("rr_c1_l1", 64'(o_cdb_tag[1]), 64'h11);
    step();
    check_eq("rr_c2_l0", 64'(o_cdb_tag[0]), 64'h12);
    check_eq("rr_c2_l1", 64'(o_cdb_tag[1]), 64'h13);
    // Pointer should be back at 0: FU0 must win lane 0 over FU3
    set_fu(3, 5'h1D, 32'h3333_3333);
    set_fu(0, 5'h1A, 32'h0000_AAAA);
    step();
    set_idle();
    step();
    check_eq("rr_wrap_l0", 64'(o_cdb_tag[0]), 64'h1A);
    check_eq("rr_wrap_l1", 64'(o_cdb_tag[1]), 64'h1D);

    // Backpressure: every FU saturating, two lanes draining
    saw_full1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_idle();
      for (int f = 0; f < FU; f++) set_rand(f, 100);
      step();
      saw_full1 = saw_full1 | o_fu_full[1];
    end
    check_eq("bp_full1_seen", 64'(saw_full1), 64'd1);
    set_idle();
    for (int c = 0; c < 6; c++) step();

    // Flush with full FIFOs, then a fresh result must arrive with 2-cycle latency
    for (int c = 0; c < 4; c++) begin
      set_idle();
      for (int f = 0; f < FU; f++) set_rand(f, 100);
      step();
    end
    set_idle();
    stim_flush = 1'b1;
    for (int f = 0; f < FU; f++) set_fu(f, 5'h1F, 32'hBAD0_0000);
    step();
    set_idle();
    check_eq("flush_en0", 64'(o_cdb_en[0]), 64'd0);
    check_eq("flush_en1", 64'(o_cdb_en[1]), 64'd0);
    step();
    set_fu(1, 5'h1E, 32'hC0FFEE00);
    step();
    set_idle();
    check_eq("post_flush_lat1", 64'(o_cdb_en[0]), 64'd0);
    step();
    check_eq("post_flush_en", 64'(o_cdb_en[0]), 64'd1);
    check_eq("post_flush_tag", 64'(o_cdb_tag[0]), 64'h1E);
    step();

    // Fairness: FU0 continuous, FU3 one result
    fu3_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_idle();
      set_rand(0, 100);
      if (c == 0) set_fu(3, 5'h1C, 32'hFA1F_0003);
      step();
      for (int k = 0; k < CDB; k++)
        if (o_cdb_en[k] && o_cdb_tag[k] == 5'h1C) fu3_seen = 1'b1;
    end
    check_eq("fair_fu3_seen", 64'(fu3_seen), 64'd1);
    set_idle();
    for (int c = 0; c < 4; c++) step();

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      set_idle();
      for (int f = 0; f < FU; f++) set_rand(f, 55);
      if ($urandom_range(0, 99) < 3) stim_flush = 1'b1;
      if ($urandom_range(0, 99) < 1) stim_rst = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
